fetch_pc_ctrl: RTL

- Upstream neighbour of the fetch stage. Owns the fetch PC register and drives the instruction-bus request address and valid.
- Keeps the request stable while it is outstanding, absorbs back-end stalls, and applies branch redirects.
- When a redirect arrives mid-request, it cancels the in-flight wrong-path instruction.
- Produces pc_nxt, plus a per-cycle accept/flush qualifier that fetch uses to mark bubbles.

---
 rtl/fetch_pc_ctrl_pkg.sv | 9 +
 rtl/fetch_pc_ctrl_if.sv | 16 +
 rtl/fetch_pc_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared fetch PC constants, FSM state type and target alignment helper
package fetch_pc_ctrl_pkg;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
  localparam int DEFAULT_INSTR_BYTES = 4;
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} fetch_pc_state_t;
  function automatic logic [63:0] align_pc(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: back-end control, instruction-bus request/response and fetch qualifier signals
interface fetch_pc_ctrl_if;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        iresp_data_ok;
  logic [63:0] pc_nxt;
  logic        ireq_valid;
  logic        fetch_accept;
  logic [63:0] fetch_pc;
  logic        fetch_busy;
  modport master (output stall, redirect_valid, redirect_pc, iresp_data_ok,
                  input pc_nxt, ireq_valid, fetch_accept, fetch_pc, fetch_busy);
  modport slave (input stall, redirect_valid, redirect_pc, iresp_data_ok,
                 output pc_nxt, ireq_valid, fetch_accept, fetch_pc, fetch_busy);
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch PC register and instruction-bus request control with stall hold and redirect flush
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input logic clk,
  input logic reset,
  fetch_pc_ctrl_if.slave bus
);
  fetch_pc_state_t state_q, state_d;
  logic [63:0] pc_q, pc_d, pend_q, pend_d, pc_inc, tgt;
  logic valid, accept;
  assign pc_inc = pc_q + 64'(INSTR_BYTES);
  assign tgt = align_pc(bus.redirect_pc);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      pend_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    valid = 1'b0;
    accept = 1'b0;
    case (state_q)
      RUN: begin
        valid = 1'b1;
        if (bus.iresp_data_ok) begin
          if (bus.redirect_valid) pc_d = tgt;
          else begin
            accept = 1'b1;
            if (bus.stall) state_d = HOLD;
            else pc_d = pc_inc;
          end
        end else if (bus.redirect_valid) begin
          pend_d = tgt;
          state_d = FLUSH;
        end
      end
      HOLD: begin
        // redirect beats stall release
        if (bus.redirect_valid || !bus.stall) begin
          pc_d = bus.redirect_valid ? tgt : pc_inc;
          state_d = RUN;
        end
      end
      default: begin
        valid = 1'b1;
        if (bus.redirect_valid) pend_d = tgt;
        if (bus.iresp_data_ok) begin
          pc_d = bus.redirect_valid ? tgt : pend_q;
          state_d = RUN;
        end
      end
    endcase
  end
  assign bus.pc_nxt = reset ? RESET_PC : pc_q;
  assign bus.fetch_pc = bus.pc_nxt;
  assign bus.ireq_valid = valid & ~reset;
  assign bus.fetch_accept = accept & ~reset;
  assign bus.fetch_busy = bus.ireq_valid & ~bus.iresp_data_ok;
endmodule
